mod_m_timer_ctrl: RTL



---
 rtl/mod_m_timer_pkg.sv | 21 ++
 rtl/mod_m_prescaler.sv | 38 +++
 rtl/mod_m_timer_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mod_m_timer_pkg.sv
// Shared types for the mod-m interval timer controller.
package mod_m_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // RUN and HOLD together make up an active timing interval.
  function automatic logic is_active(state_e s);
    return (s == S_RUN) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/mod_m_prescaler.sv
// Mod-m prescaler: counts 0..m_eff-1 while enabled, flags the wrap cycle.
module mod_m_prescaler #(
  parameter int unsigned N = 4
) (
  input  logic         clk_amisha,
  input  logic         reset_amisha,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] m_eff,
  output logic [N-1:0] q,
  output logic         max_tick
);

  logic [N-1:0] q_q, q_d;
  logic         at_top;

  // Next count: clear has priority, otherwise wrap at m_eff-1.
  always_comb begin
    at_top   = (q_q == m_eff - N'(1));
    max_tick = en && at_top;
    q_d      = q_q;
    if (clr)
      q_d = '0;
    else if (en)
      q_d = at_top ? '0 : q_q + N'(1);
  end

  // Count register.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mod_m_timer_ctrl.sv
// Programmable interval timer built around a mod-m prescaler.
// Optional latched completion interrupt: define MOD_M_TIMER_CTRL_IRQ_EN.
module mod_m_timer_ctrl #(
  parameter int unsigned N         = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned M_DEFAULT = 10
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             start_amisha,
  input  logic             stop_amisha,
  input  logic             pause_amisha,
  input  logic             mode_amisha,
  input  logic [N-1:0]     m_in_amisha,
  input  logic [CNT_W-1:0] periods_in_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic             max_tick_amisha,
  output logic [N-1:0]     q_amisha,
  output logic [CNT_W-1:0] period_cnt_amisha
`ifdef MOD_M_TIMER_CTRL_IRQ_EN
  ,
  input  logic             irq_clr_amisha,
  output logic             irq_amisha
`endif
);

  import mod_m_timer_pkg::*;

  state_e           state_q;
  mode_e            mode_q;
  logic [N-1:0]     m_eff_q, m_eff_d;
  logic [CNT_W-1:0] periods_q, periods_d;
  logic [CNT_W-1:0] period_cnt_q;
  logic             busy_q, done_q;

  logic             counting, start_acc, pre_clr;
  logic             tick, final_tick, done_set;

  // Operand defaults, datapath control and completion detection.
  // Counting is gated by the pause level in HOLD as well as RUN, so the
  // cycle in which pause drops already advances the count: a pause of k
  // cycles delays completion by exactly k cycles.
  always_comb begin
    m_eff_d    = (m_in_amisha == '0) ? N'(M_DEFAULT) : m_in_amisha;
    periods_d  = (periods_in_amisha == '0) ? CNT_W'(1) : periods_in_amisha;
    counting   = is_active(state_q) && !pause_amisha;
    start_acc  = (state_q == S_IDLE) && start_amisha && !stop_amisha;
    pre_clr    = start_acc || stop_amisha;
    final_tick = tick && (period_cnt_q == periods_q - CNT_W'(1));
    done_set   = final_tick && !stop_amisha;
  end

  mod_m_prescaler #(.N(N)) u_prescaler (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .en           (counting),
    .clr          (pre_clr),
    .m_eff        (m_eff_q),
    .q            (q_amisha),
    .max_tick     (tick)
  );

  // Control FSM with registered busy/done and period counter.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_ONESHOT;
      m_eff_q      <= '0;
      periods_q    <= '0;
      period_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= done_set;
      if (stop_amisha) begin
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        period_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_amisha) begin
              m_eff_q      <= m_eff_d;
              periods_q    <= periods_d;
              mode_q       <= mode_e'(mode_amisha);
              period_cnt_q <= '0;
              busy_q       <= 1'b1;
              state_q      <= S_RUN;
            end
          end
          S_RUN, S_HOLD: begin
            if (pause_amisha) begin
              state_q <= S_HOLD;
            end else begin
              state_q <= S_RUN;
              if (final_tick) begin
                period_cnt_q <= '0;
                if (mode_q == MODE_ONESHOT) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                end
              end else if (tick) begin
                period_cnt_q <= period_cnt_q + CNT_W'(1);
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_amisha       = busy_q;
  assign done_amisha       = done_q;
  assign max_tick_amisha   = tick;
  assign period_cnt_amisha = period_cnt_q;

`ifdef MOD_M_TIMER_CTRL_IRQ_EN
  logic irq_q;

  // Sticky completion flag; a new completion wins over a clear.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha)
      irq_q <= 1'b0;
    else if (done_set)
      irq_q <= 1'b1;
    else if (irq_clr_amisha)
      irq_q <= 1'b0;
  end

  assign irq_amisha = irq_q;
`endif

endmodule
